tdm_slot_mux: RTL

- Downstream consumer of the 4-bit one-hot ring counter output.
- Uses the rotating one-hot slot vector as a strict time-division schedule to merge four valid/ready input channels into one registered output stream.
- Each channel is buffered in a small FIFO; a channel may emit only during its own slot.
- Sits between the ring counter and any shared single-port consumer, e.g. a serial link or display driver.

---
 rtl/tdm_pkg.sv | 30 +++
 rtl/chan_fifo.sv | 65 ++++++
 rtl/tdm_slot_mux.sv | 109 ++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and slot-decode helpers for the TDM slot multiplexer.
package tdm_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  typedef logic [NUM_CH-1:0]   ch_vec_t;
  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // True when exactly one bit of the slot vector is set.
  function automatic logic is_onehot(input ch_vec_t v);
    logic [CH_IDX_W:0] ones;
    ones = {(CH_IDX_W+1){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      ones = ones + {{CH_IDX_W{1'b0}}, v[i]};
    end
    return (ones == (CH_IDX_W+1)'(1));
  endfunction

  // Index of the set bit; OR-encoded, so only meaningful for a one-hot input.
  function automatic ch_idx_t onehot_to_idx(input ch_vec_t v);
    ch_idx_t idx;
    idx = {CH_IDX_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      idx = idx | (v[i] ? CH_IDX_W'(i) : {CH_IDX_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Small per-channel FIFO: registered storage, pointers wrap modulo DEPTH.
module chan_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // Overflow/underflow are blocked here as well as by the caller.
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == {CNT_W{1'b0}});
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage write at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tdm_slot_mux.sv
// Strict TDM merge of four valid/ready channels into one registered output,
// scheduled by a one-hot ring-counter slot vector.
module tdm_slot_mux
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        slot,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_IDX_W-1:0]      out_chan,
  input  logic                     out_ready,
  output logic                     slot_err
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [NUM_CH-1:0]   w_full;
  logic [NUM_CH-1:0]   w_empty;
  logic [NUM_CH-1:0]   w_push;
  logic [NUM_CH-1:0]   w_pop;
  logic [DATA_W-1:0]   w_head  [NUM_CH];
  logic [CNT_W-1:0]    w_count [NUM_CH];
  logic                w_slot_ok;
  logic [CH_IDX_W-1:0] w_sel;
  logic                w_deq;

  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic [CH_IDX_W-1:0] r_out_chan;
  logic                r_slot_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    // Ready comes only from stored occupancy, never from out_ready.
    assign in_ready[g] = (w_count[g] < CNT_W'(DEPTH));
    assign w_push[g]   = in_valid[g] & ~w_full[g];

    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push[g]),
      .push_data (in_data[g*DATA_W +: DATA_W]),
      .pop       (w_pop[g]),
      .head_data (w_head[g]),
      .count     (w_count[g]),
      .full      (w_full[g]),
      .empty     (w_empty[g])
    );
  end

  // A slot is used only by its owner; an empty slot stays idle, and a stalled
  // output register forfeits the slot.
  assign w_slot_ok = is_onehot(slot);
  assign w_sel     = onehot_to_idx(slot);
  assign w_deq     = w_slot_ok & ~w_empty[w_sel] & (~r_out_valid | out_ready);

  // Pop strobe to the granted FIFO only.
  always_comb begin
    w_pop = {NUM_CH{1'b0}};
    if (w_deq) begin
      w_pop[w_sel] = 1'b1;
    end else begin
      w_pop = {NUM_CH{1'b0}};
    end
  end

  // Output register: load on dequeue, drop valid after an accepted word, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_W{1'b0}};
      r_out_chan  <= {CH_IDX_W{1'b0}};
    end else if (w_deq) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_head[w_sel];
      r_out_chan  <= w_sel;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Sticky record of any malformed slot vector; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_err <= 1'b0;
    end else if (!w_slot_ok) begin
      r_slot_err <= 1'b1;
    end else begin
      r_slot_err <= r_slot_err;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign slot_err  = r_slot_err;

endmodule
